mem_data_arbiter: RTL and testbench
===================================

# mem_data_arbiter

Two-port arbiter that shares the single data RAM (`mem_data_ram`) between the CPU load/store port (port 0) and a secondary master such as a DMA/program loader (port 1). It sits between the requesters and the RAM's `addr_bus`/`write_data_bus`/`write_signal`/`read_data_bus` and grants one single-beat transaction per cycle to the owning port. Arbitration is round-robin with an optional bounded lock for short bursts.

## Interface
- `ADDR_W`, 32, address width, same for both ports and the RAM.
- `DATA_W`, 32, data width.
- `MAX_HOLD`, 4, maximum consecutive beats a locked owner keeps the RAM while the other port waits; legal range ≥1.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req0`, `req1`  in  1  transaction request, held until acked.
- `we0`, `we1`  in  1  1 = write, 0 = read.
- `lock0`, `lock1`  in  1  request to keep ownership for the next beat.
- `addr0`, `addr1`  in  ADDR_W  byte address.
- `wdata0`, `wdata1`  in  DATA_W  write data.
- `ack0`, `ack1`  out  1  beat completed this cycle.
- `rdata0`, `rdata1`  out  DATA_W  read data, valid when the matching ack is 1.
- `ram_addr_bus`  out  ADDR_W  to RAM `addr_bus`.
- `ram_write_data_bus`  out  DATA_W  to RAM `write_data_bus`.
- `ram_write_signal`  out  1  to RAM `write_signal`.
- `ram_read_data_bus`  in  DATA_W  from RAM, combinational read.
- `grant`  out  2  registered owner: 2'b00 none, 2'b01 port 0, 2'b10 port 1.

## Operation
- States: IDLE, OWN0, OWN1, held in a register. `grant` decodes the state.
- Registers: `last` (last port served), `hold_cnt` (consecutive acked beats in the current ownership, saturating at MAX_HOLD-1).
- In OWNx with `reqx`=1, a beat occurs: `ackx`=1, the RAM buses are driven from port x, `ram_write_signal`=`wex`, and `rdatax`=`ram_read_data_bus`.
- In all other cases `ackx`=0, the RAM buses are 0, and the rdata outputs are 0.
- IDLE transitions:
  - Only one req high: go to that OWN.
  - Both reqs high: go to OWN of the port ≠ `last`.
  - No req: stay in IDLE.
- OWNx transitions, evaluated each cycle:
  - Other req high, and not (`reqx`·`lockx`·`hold_cnt` < MAX_HOLD-1): switch to OWN(other).
  - Else `reqx` high, or (`lockx` and the other req low): stay in OWNx (parking).
  - Else: go to IDLE.
- `last` ← x on every beat by port x.
- `hold_cnt` increments on each beat in the same ownership and clears to 0 on any state change.
- MAX_HOLD=1 disables locking.
- The owner never changes mid-beat. A beat is one cycle and is never split or retried.

## Timing
- Reset (`reset`=0 sampled on the rising edge):
  - State IDLE, `last`=1 so port 0 wins the first tie, `hold_cnt`=0.
  - All acks, rdata, RAM buses, and `grant` are 0.
- While `reset`=0, `ack*` and `ram_write_signal` are additionally forced to 0 combinationally. A write in flight during reset is therefore suppressed.
- Latency from IDLE: req high in cycle N gives ack in cycle N+1.
- A parked owner gets ack in the same cycle as its req (0-cycle latency).
- Switching ownership costs no idle cycle: the last beat of OWN0 in cycle N is followed by the first beat of OWN1 in cycle N+1.
- Requesters must hold `req`/`we`/`addr`/`wdata` stable until ack. They may drop or change them in the cycle after ack.
- Read data is combinational through the RAM within the ack cycle; there is no added read latency.
- Worst-case wait for a requesting port: MAX_HOLD beats by the other port plus 1 cycle.

## Structure
- Shared header `mem_arb_defs.vh`: state encodings ST_IDLE=2'd0, ST_OWN0=2'd1, ST_OWN1=2'd2, and the grant encodings.
- Optional sub-module `rr_pick2`: combinational two-way round-robin picker (inputs `req0`, `req1`, `last`; output winner).
- `hold_cnt` width is $clog2(MAX_HOLD)+1.
- Instantiated in the SoC between `rv32e_cpu` (port 0) and `mem_data_ram`. Port 1 is tied off (`req1`=0) when unused.

## Test plan
- Reset release, only `req0`=1 with a read of addr 0x10: `grant`=01 and `ack0`=1 one cycle later. `rdata0` equals the RAM word at 0x10. `ack1` stays 0.
- `req0`=`req1`=1 both unlocked, from IDLE after reset: beats alternate port 0, 1, 0, 1 on consecutive cycles. No idle gaps, `ram_write_signal` follows the owning `we`.
- MAX_HOLD=4, port 1 writes locked while `req0` waits: exactly 4 consecutive `ack1`, then `ack0` on the next cycle.
- Port 0 parked alone writing 0xDEADBEEF to 0x20, then reading it back: ack in the same cycle as req. The readback returns 0xDEADBEEF.
- `reset` driven low in a cycle where OWN1 presents a write: `ram_write_signal`=0 that cycle. Next cycle `grant`=00, and the RAM word is unchanged.
- `req1` dropped the cycle after its ack while `req0` is idle: state goes to IDLE. Re-asserting `req1` is acked one cycle later (N+1 latency).

Source files
------------

// File: rtl/mem_data_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_data_arbiter_pkg
// Shared definitions for the data-RAM arbiter: ownership state encodings,
// grant encodings, and a helper that turns an ownership state into the
// externally visible grant vector.
// ---------------------------------------------------------------------------
package mem_data_arbiter_pkg;

    // Ownership states of the arbiter FSM
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    // One-hot grant encodings presented on the grant output
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_P0   = 2'b01;
    localparam logic [1:0] GRANT_P1   = 2'b10;

    // Decode an ownership state into the grant vector; the unused encoding
    // reads as "no owner" so a corrupted state never shows a false grant.
    function automatic logic [1:0] stateToGrant(input logic [1:0] state);
        logic [1:0] grantValue;
        case (state)
            ST_OWN0: grantValue = GRANT_P0;
            ST_OWN1: grantValue = GRANT_P1;
            default: grantValue = GRANT_NONE;
        endcase
        return grantValue;
    endfunction

endpackage

// File: rtl/mem_data_arbiter_rr_pick2.sv
// ---------------------------------------------------------------------------
// mem_data_arbiter_rr_pick2
// Combinational two-way round-robin picker.
//
// Ports:
//   i_req0, i_req1 : requests from port 0 / port 1
//   i_last         : port served most recently (0 or 1)
//   o_winner       : port that should own the RAM next (0 or 1); only
//                    meaningful when at least one request is high
// ---------------------------------------------------------------------------
module mem_data_arbiter_rr_pick2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_winner
);

    // On a tie the port that was not served last wins; otherwise the single
    // requester wins (port 1 only if it is the one asking).
    always_comb begin
        o_winner = i_req1;
        if (i_req0 && i_req1) begin
            o_winner = ~i_last;
        end
    end

endmodule

// File: rtl/mem_data_arbiter.sv
// ---------------------------------------------------------------------------
// mem_data_arbiter
// Shares the single data RAM between the CPU load/store port (port 0) and a
// secondary master (port 1). One single-beat transaction per cycle is granted
// to the owning port; ownership is round-robin with an optional bounded lock.
//
// Ports:
//   clk, reset                    : clock, synchronous active-low reset
//   req*/we*/lock*/addr*/wdata*   : per-port request, write enable, lock,
//                                   byte address, write data
//   ack*, rdata*                  : per-port beat completion and read data
//   ram_addr_bus, ram_write_data_bus, ram_write_signal : to the RAM
//   ram_read_data_bus             : combinational read data from the RAM
//   grant                         : registered owner (00 none, 01 p0, 10 p1)
// ---------------------------------------------------------------------------
module mem_data_arbiter
    import mem_data_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_addr_bus,
    output logic [DATA_W-1:0] ram_write_data_bus,
    output logic              ram_write_signal,
    input  logic [DATA_W-1:0] ram_read_data_bus,
    output logic [1:0]        grant
);

    localparam int                HOLD_W     = $clog2(MAX_HOLD) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_stateNext;
    logic              r_last;
    logic [HOLD_W-1:0] r_holdCnt;
    logic              w_winner;
    logic              w_beat0;
    logic              w_beat1;
    logic              w_holdOpen;
    logic              w_keep0;
    logic              w_keep1;

    mem_data_arbiter_rr_pick2 u_pick (
        .i_req0   (req0),
        .i_req1   (req1),
        .i_last   (r_last),
        .o_winner (w_winner)
    );

    // A beat happens whenever the owner is requesting; a locked owner may
    // only keep the RAM against a waiting port while the hold budget lasts.
    assign w_beat0    = (r_state == ST_OWN0) && req0;
    assign w_beat1    = (r_state == ST_OWN1) && req1;
    assign w_holdOpen = (r_holdCnt < HOLD_LIMIT);
    assign w_keep0    = req0 && lock0 && w_holdOpen;
    assign w_keep1    = req1 && lock1 && w_holdOpen;

    // Next ownership. An owner with no request but a lock, and no competitor,
    // stays parked so its next request is served with zero latency.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    w_stateNext = w_winner ? ST_OWN1 : ST_OWN0;
                end
            end
            ST_OWN0: begin
                if (req1 && !w_keep0) begin
                    w_stateNext = ST_OWN1;
                end else if (req0 || (lock0 && !req1)) begin
                    w_stateNext = ST_OWN0;
                end else begin
                    w_stateNext = ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (req0 && !w_keep1) begin
                    w_stateNext = ST_OWN0;
                end else if (req1 || (lock1 && !req0)) begin
                    w_stateNext = ST_OWN1;
                end else begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // State, last-served port and hold counter. The counter restarts on any
    // ownership change and saturates at the hold limit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_last    <= 1'b1;
            r_holdCnt <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_beat0) begin
                r_last <= 1'b0;
            end else if (w_beat1) begin
                r_last <= 1'b1;
            end
            if (w_stateNext != r_state) begin
                r_holdCnt <= '0;
            end else if ((w_beat0 || w_beat1) && w_holdOpen) begin
                r_holdCnt <= r_holdCnt + HOLD_W'(1);
            end
        end
    end

    // Route the owning port onto the RAM buses. Acks and the write strobe are
    // squashed during reset so an in-flight write never reaches the RAM.
    always_comb begin
        ack0               = 1'b0;
        ack1               = 1'b0;
        rdata0             = '0;
        rdata1             = '0;
        ram_addr_bus       = '0;
        ram_write_data_bus = '0;
        ram_write_signal   = 1'b0;
        if (w_beat0) begin
            ack0               = 1'b1;
            rdata0             = ram_read_data_bus;
            ram_addr_bus       = addr0;
            ram_write_data_bus = wdata0;
            ram_write_signal   = we0;
        end else if (w_beat1) begin
            ack1               = 1'b1;
            rdata1             = ram_read_data_bus;
            ram_addr_bus       = addr1;
            ram_write_data_bus = wdata1;
            ram_write_signal   = we1;
        end
        if (!reset) begin
            ack0             = 1'b0;
            ack1             = 1'b0;
            ram_write_signal = 1'b0;
        end
    end

    assign grant = stateToGrant(r_state);

endmodule

// File: tb/tb_mem_data_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_data_arbiter
// Self-checking bench for mem_data_arbiter: a behavioural RAM, a reference
// model of ownership/acks kept as plain integers, directed scenarios and a
// randomized protocol-respecting traffic phase.
// ---------------------------------------------------------------------------
module tb_mem_data_arbiter;

    localparam int MAX_HOLD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] ram_addr_bus, ram_write_data_bus, ram_read_data_bus;
    logic        ram_write_signal;
    logic [1:0]  grant;

    // Behavioural RAM and the bench's independent view of its contents
    logic [31:0] ramMem [64];
    logic [31:0] shadow [64];
    logic        ramReady = 1'b0;

    // Reference model state: owner 0 = none, 1 = port 0, 2 = port 1
    int mOwner, mLast, mHold;
    logic expAck0, expAck1;
    int nVectors = 0;
    int nMiss    = 0;
    logic pending0, pending1;

    mem_data_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(MAX_HOLD)) dut (
        .clk                (clk),
        .reset              (reset),
        .req0               (req0),
        .req1               (req1),
        .we0                (we0),
        .we1                (we1),
        .lock0              (lock0),
        .lock1              (lock1),
        .addr0              (addr0),
        .addr1              (addr1),
        .wdata0             (wdata0),
        .wdata1             (wdata1),
        .ack0               (ack0),
        .ack1               (ack1),
        .rdata0             (rdata0),
        .rdata1             (rdata1),
        .ram_addr_bus       (ram_addr_bus),
        .ram_write_data_bus (ram_write_data_bus),
        .ram_write_signal   (ram_write_signal),
        .ram_read_data_bus  (ram_read_data_bus),
        .grant              (grant)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] initWord(input int idx);
        return 32'hC0DE0000 + 32'(idx) * 32'h101;
    endfunction

    // RAM: preload on the first edge, then write on the strobe
    always @(posedge clk) begin
        if (!ramReady) begin
            for (int i = 0; i < 64; i++) ramMem[i] <= initWord(i);
            ramReady <= 1'b1;
        end else if (ram_write_signal) begin
            ramMem[ram_addr_bus[7:2]] <= ram_write_data_bus;
        end
    end

    assign ram_read_data_bus = ramMem[ram_addr_bus[7:2]];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVectors++;
        assert (obs === exp) else begin
            nMiss++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check every output against the model at the falling
    // edge, then advance the model on the rising edge.
    task automatic applyStimulus();
        logic b0, b1, eWs, myReq, othReq, myLock, keep;
        logic [31:0] eAddr, eWdata;
        logic [1:0]  eGrant;
        int nxt, me;
        @(negedge clk);
        b0      = (mOwner == 1) && req0;
        b1      = (mOwner == 2) && req1;
        expAck0 = b0 && reset;
        expAck1 = b1 && reset;
        eAddr   = b0 ? addr0 : (b1 ? addr1 : 32'h0);
        eWdata  = b0 ? wdata0 : (b1 ? wdata1 : 32'h0);
        eWs     = reset && ((b0 && we0) || (b1 && we1));
        eGrant  = (mOwner == 1) ? 2'b01 : ((mOwner == 2) ? 2'b10 : 2'b00);
        checkOutput("ack0", ack0, expAck0);
        checkOutput("ack1", ack1, expAck1);
        checkOutput("rdata0", rdata0, b0 ? shadow[addr0[7:2]] : 32'h0);
        checkOutput("rdata1", rdata1, b1 ? shadow[addr1[7:2]] : 32'h0);
        checkOutput("ram_addr", ram_addr_bus, eAddr);
        checkOutput("ram_wdata", ram_write_data_bus, eWdata);
        checkOutput("ram_we", ram_write_signal, eWs);
        checkOutput("grant", grant, eGrant);
        @(posedge clk);
        if (eWs) shadow[eAddr[7:2]] = eWdata;
        if (!reset) begin
            mOwner = 0;
            mLast  = 1;
            mHold  = 0;
        end else begin
            if (mOwner == 0) begin
                if (req0 && req1) nxt = (mLast == 0) ? 2 : 1;
                else if (req0)    nxt = 1;
                else if (req1)    nxt = 2;
                else              nxt = 0;
            end else begin
                me     = mOwner - 1;
                myReq  = (me == 0) ? req0 : req1;
                othReq = (me == 0) ? req1 : req0;
                myLock = (me == 0) ? lock0 : lock1;
                keep   = myReq && myLock && (mHold < MAX_HOLD - 1);
                if (othReq && !keep)                 nxt = 2 - me;
                else if (myReq || (myLock && !othReq)) nxt = mOwner;
                else                                 nxt = 0;
            end
            if (b0) mLast = 0;
            if (b1) mLast = 1;
            if (nxt != mOwner) mHold = 0;
            else if ((b0 || b1) && mHold < MAX_HOLD - 1) mHold++;
            mOwner = nxt;
        end
        #1;
    endtask

    initial begin
        reset = 1'b0;
        {req0, req1, we0, we1, lock0, lock1} = '0;
        {addr0, addr1, wdata0, wdata1} = '0;
        for (int i = 0; i < 64; i++) shadow[i] = initWord(i);
        repeat (2) @(posedge clk);
        #1;
        mOwner = 0; mLast = 1; mHold = 0;

        // Reset state
        checkOutput("rst_grant", grant, 2'b00);
        checkOutput("rst_ack0", ack0, 1'b0);
        checkOutput("rst_ack1", ack1, 1'b0);
        checkOutput("rst_ram_we", ram_write_signal, 1'b0);
        checkOutput("rst_ram_addr", ram_addr_bus, 32'h0);
        applyStimulus();

        // Single read by port 0 from IDLE: ack one cycle later
        reset = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        applyStimulus();
        checkOutput("rd_grant", grant, 2'b01);
        checkOutput("rd_ack0", ack0, 1'b1);
        checkOutput("rd_rdata0", rdata0, initWord(4));
        checkOutput("rd_ack1", ack1, 1'b0);
        applyStimulus();
        req0 = 1'b0;
        applyStimulus();

        // Both ports unlocked from reset: strict alternation 0,1,0,1
        reset = 1'b0;
        applyStimulus();
        reset = 1'b1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wdata0 = $urandom;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h44;
        applyStimulus();
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("alt_ack0_%0d", k), ack0, (k % 2) == 0);
            checkOutput($sformatf("alt_ack1_%0d", k), ack1, (k % 2) == 1);
            checkOutput($sformatf("alt_we_%0d", k), ram_write_signal, (k % 2) == 0);
            applyStimulus();
        end
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0;
        repeat (2) applyStimulus();

        // Port 1 locked writes while port 0 waits: exactly MAX_HOLD beats
        reset = 1'b0;
        applyStimulus();
        reset = 1'b1;
        req1 = 1'b1; we1 = 1'b1; lock1 = 1'b1; addr1 = 32'h30; wdata1 = $urandom;
        applyStimulus();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h34;
        for (int k = 0; k < MAX_HOLD; k++) begin
            checkOutput($sformatf("lock_ack1_%0d", k), ack1, 1'b1);
            checkOutput($sformatf("lock_ack0_%0d", k), ack0, 1'b0);
            applyStimulus();
        end
        checkOutput("lock_switch_ack0", ack0, 1'b1);
        checkOutput("lock_switch_ack1", ack1, 1'b0);
        req1 = 1'b0; lock1 = 1'b0; we1 = 1'b0;
        applyStimulus();
        req0 = 1'b0;
        applyStimulus();

        // Port 0 parked alone: zero-latency write then readback
        req0 = 1'b1; we0 = 1'b0; lock0 = 1'b1; addr0 = 32'h08;
        applyStimulus();
        applyStimulus();
        req0 = 1'b0;
        applyStimulus();
        checkOutput("park_grant", grant, 2'b01);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'hDEADBEEF;
        #1;
        checkOutput("park_wr_ack0", ack0, 1'b1);
        applyStimulus();
        req0 = 1'b0; we0 = 1'b0;
        applyStimulus();
        req0 = 1'b1;
        #1;
        checkOutput("park_rd_ack0", ack0, 1'b1);
        checkOutput("park_rd_data", rdata0, 32'hDEADBEEF);
        applyStimulus();
        req0 = 1'b0; lock0 = 1'b0;
        applyStimulus();

        // Reset during an OWN1 write: write suppressed, RAM untouched
        req1 = 1'b1; we1 = 1'b1; lock1 = 1'b1; addr1 = 32'h50; wdata1 = 32'h12345678;
        applyStimulus();
        reset = 1'b0;
        #1;
        checkOutput("rstwr_we", ram_write_signal, 1'b0);
        checkOutput("rstwr_ack1", ack1, 1'b0);
        applyStimulus();
        checkOutput("rstwr_grant", grant, 2'b00);
        checkOutput("rstwr_ram", ramMem[20], initWord(20));
        reset = 1'b1; req1 = 1'b0; lock1 = 1'b0; we1 = 1'b0;
        applyStimulus();

        // Port 1 drops after its ack: back to IDLE, re-request costs a cycle
        req1 = 1'b1; addr1 = 32'h60;
        applyStimulus();
        checkOutput("drop_ack1_first", ack1, 1'b1);
        applyStimulus();
        req1 = 1'b0;
        applyStimulus();
        checkOutput("drop_grant_idle", grant, 2'b00);
        req1 = 1'b1;
        #1;
        checkOutput("drop_reack_early", ack1, 1'b0);
        applyStimulus();
        checkOutput("drop_reack", ack1, 1'b1);
        applyStimulus();
        req1 = 1'b0;
        applyStimulus();

        // Randomized traffic obeying the hold-until-ack protocol
        pending0 = 1'b0;
        pending1 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 59) != 0);
            lock0 = $urandom_range(0, 1) == 1;
            lock1 = $urandom_range(0, 1) == 1;
            if (!pending0) begin
                pending0 = $urandom_range(0, 2) != 0;
                req0     = pending0;
                we0      = $urandom_range(0, 1) == 1;
                addr0    = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                wdata0   = $urandom;
            end
            if (!pending1) begin
                pending1 = $urandom_range(0, 2) != 0;
                req1     = pending1;
                we1      = $urandom_range(0, 1) == 1;
                addr1    = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                wdata1   = $urandom;
            end
            applyStimulus();
            if (expAck0) pending0 = 1'b0;
            if (expAck1) pending1 = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
        $finish;
    end

endmodule
